midori64_share_driver: RTL
==========================

Name: midori64_share_driver

Overview:
Host-side initiator for the 2-share masked Midori64 core. Accepts an unmasked 64-bit block, 128-bit key and direction over a valid/ready handshake. Splits the block into two Boolean shares and runs the core through its reset-load / run / done protocol. Recombines the output shares into one result returned over a valid/ready handshake. Sits between the system bus/test harness and the Midori64 instance.

Parameters:
TIMEOUT, 64, max cycles to wait for core_done after run starts; must be >= 2.
LOAD_CYCLES, 2, cycles core_reset is held high with operands stable before run; must be >= 1.
MASK_SEED, 64'h0123456789ABCDEF, LFSR reset value; must be non-zero.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  request present.
in_ready  out  1  driver idle, request accepted when in_valid & in_ready.
in_data  in  64  unmasked plaintext/ciphertext.
in_key  in  128  key.
in_enc_dec  in  1  direction, passed unchanged to core_enc_dec.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts the result.
out_data  out  64  recombined result.
out_err  out  1  timeout flag, qualified by out_valid.
core_reset  out  1  to core reset (high = load/hold).
core_input1  out  64  share 1.
core_input2  out  64  share 2.
core_key  out  128  registered key.
core_enc_dec  out  1  registered direction.
core_done  in  1  from core.
core_output1  in  64  from core.
core_output2  in  64  from core.

Behaviour:
- Reset values: state IDLE; in_ready=1; out_valid=0; out_data=0; out_err=0; core_reset=1; core_input1/2=0; core_key=0; core_enc_dec=0; LFSR=MASK_SEED; counters=0.
- Core operands are registers. They change only on request acceptance and stay stable until the next acceptance.
- States:
  - IDLE: in_ready=1, core_reset=1. On in_valid, capture the request:
    - core_input2 <= mask; core_input1 <= in_data ^ mask.
    - core_key <= in_key; core_enc_dec <= in_enc_dec.
    - LFSR advances one step; load counter cleared; go LOAD.
  - LOAD: core_reset=1, in_ready=0. Holds LOAD_CYCLES cycles, then goes RUN.
  - RUN: core_reset=0, in_ready=0. Cycle counter increments each cycle.
    - First cycle with core_done=1: out_data <= core_output1 ^ core_output2, out_err <= 0, go OUT.
    - Counter reaches TIMEOUT with no done: out_data <= 0, out_err <= 1, go OUT.
    - Done and timeout in the same cycle: done wins.
  - OUT: out_valid=1, core_reset=1 (core halted), in_ready=0. out_data/out_err held stable while out_ready=0. On out_ready, out_valid drops next cycle and state returns to IDLE.
- No back-to-back overlap: a new request is accepted at earliest one cycle after the output handshake.
- Latency, acceptance to out_valid: 1 + LOAD_CYCLES + core latency cycles.
- core_done arriving while not in RUN is ignored.
- Async reset mid-operation: immediate return to reset values. Any pending result is discarded and core_reset is forced high asynchronously.
- LFSR: 64-bit Galois, polynomial x^64+x^63+x^61+x^60+1. Steps only on acceptance, so the mask sequence is deterministic per reset.

Optional Feature:
Macro MIDORI_DRIVER_MASK_EN.
- Defined: mask comes from the LFSR as above.
- Undefined: LFSR is not synthesised, mask=0, so core_input1=in_data and core_input2=0. This is the unmasked debug mode. All other timing and state behaviour is identical.

Test Plan:
1. Encrypt: in_key=0, in_data=0, in_enc_dec=0 -> out_data=64'h3c9cceda2bbd449a, out_err=0; core_input1^core_input2 == 0 throughout.
2. Decrypt: in_key=0, in_data=64'h3c9cceda2bbd449a, in_enc_dec=1 -> out_data=0. With the macro defined, core_input2 equals the LFSR value one step past MASK_SEED (the first mask, MASK_SEED, was consumed by test 1).
3. Encrypt: key 128'h687ded3b3c85b3f35b1009863e2a8cbf, in_data=64'h42c20fd3b586879e -> out_data=64'h66bcdc6270d901cd.
4. Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0, core_reset=1; release -> IDLE next cycle.
5. Timeout: stub core with core_done tied 0 -> out_valid with out_err=1, out_data=0 exactly TIMEOUT cycles after entering RUN.
6. Reset mid-RUN: assert reset between clock edges -> core_reset=1 and out_valid=0 immediately; the next request completes correctly.

Source files
------------

// File: rtl/midori64_share_driver_if.sv
// Host-side request/response bundle for midori64_share_driver.
// master = host/test harness, slave = the driver.
interface midori64_share_driver_if;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic [127:0] in_key;
    logic         in_enc_dec;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         out_err;

    modport master (
        output in_valid, in_data, in_key, in_enc_dec, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_key, in_enc_dec, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/midori64_share_driver.sv
// Host-side initiator for a 2-share masked Midori64 core: shares the block, sequences the core
// through load/run/done, recombines the result. Define MIDORI_DRIVER_MASK_EN for LFSR masks.
module midori64_share_driver #(
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned LOAD_CYCLES = 2,
    parameter logic [63:0] MASK_SEED   = 64'h0123456789ABCDEF
) (
    input  logic                   clk,
    input  logic                   reset,
    midori64_share_driver_if.slave io_host,
    output logic                   o_core_reset,
    output logic [63:0]            o_core_input1,
    output logic [63:0]            o_core_input2,
    output logic [127:0]           o_core_key,
    output logic                   o_core_enc_dec,
    input  logic                   i_core_done,
    input  logic [63:0]            i_core_output1,
    input  logic [63:0]            i_core_output2
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;
    localparam logic [1:0] StOut  = 2'd3;

    localparam int unsigned CntMax = (TIMEOUT > LOAD_CYCLES) ? TIMEOUT : LOAD_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    if (TIMEOUT < 2 || LOAD_CYCLES < 1 || MASK_SEED == 64'd0) begin : g_bad_params
        $error("midori64_share_driver: invalid parameter set");
    end

    logic [1:0]      r_state, w_state;
    logic [CntW-1:0] r_cnt, w_cnt;
    logic [63:0]     r_out_data, w_out_data;
    logic            r_out_err, w_out_err;
    logic [63:0]     r_in1, r_in2;
    logic [127:0]    r_key;
    logic            r_dir;
    logic            w_accept;
    logic [63:0]     w_mask;

    assign w_accept = (r_state == StIdle) && io_host.in_valid;

`ifdef MIDORI_DRIVER_MASK_EN
    // Galois LFSR, x^64+x^63+x^61+x^60+1, right-shifting; steps once per accepted request
    logic [63:0] r_lfsr;
    logic [63:0] w_lfsr_next;

    assign w_lfsr_next = {1'b0, r_lfsr[63:1]} ^ (r_lfsr[0] ? 64'hD800_0000_0000_0000 : 64'd0);
    assign w_mask      = r_lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= MASK_SEED;
        end else if (w_accept) begin
            r_lfsr <= w_lfsr_next;
        end
    end
`else
    assign w_mask = 64'd0;
`endif

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_out_data = r_out_data;
        w_out_err  = r_out_err;
        case (r_state)
            StIdle: begin
                if (io_host.in_valid) begin
                    w_state = StLoad;
                    w_cnt   = '0;
                end
            end
            StLoad: begin
                if (r_cnt == CntW'(LOAD_CYCLES - 1)) begin
                    w_state = StRun;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + CntW'(1);
                end
            end
            StRun: begin
                // done is checked first so it wins over a coincident timeout
                if (i_core_done) begin
                    w_state    = StOut;
                    w_out_data = i_core_output1 ^ i_core_output2;
                    w_out_err  = 1'b0;
                end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
                    w_state    = StOut;
                    w_out_data = 64'd0;
                    w_out_err  = 1'b1;
                end else begin
                    w_cnt = r_cnt + CntW'(1);
                end
            end
            StOut: begin
                if (io_host.out_ready) begin
                    w_state = StIdle;
                end
            end
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_out_data <= 64'd0;
            r_out_err  <= 1'b0;
            r_in1      <= 64'd0;
            r_in2      <= 64'd0;
            r_key      <= 128'd0;
            r_dir      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_out_data <= w_out_data;
            r_out_err  <= w_out_err;
            if (w_accept) begin
                r_in2 <= w_mask;
                r_in1 <= io_host.in_data ^ w_mask;
                r_key <= io_host.in_key;
                r_dir <= io_host.in_enc_dec;
            end
        end
    end

    // decoded from state so reset forces core_reset high without waiting for a clock
    assign io_host.in_ready  = (r_state == StIdle);
    assign io_host.out_valid = (r_state == StOut);
    assign io_host.out_data  = r_out_data;
    assign io_host.out_err   = r_out_err;
    assign o_core_reset      = (r_state != StRun);
    assign o_core_input1     = r_in1;
    assign o_core_input2     = r_in2;
    assign o_core_key        = r_key;
    assign o_core_enc_dec    = r_dir;
endmodule
